pc_sequencer: RTL and testbench

Program-counter and run-control block for the single-cycle core. It holds the registered instruction address and advances it by one each cycle. It redirects the address to a jump-table entry when the current instruction is a conditional branch and the ALU's `taken` flag is set. It also manages the start/done handshake with the test harness. It sits between the instruction decoder/ALU (which produce `branch`, `halt` and `taken`) and the combinational instruction memory (which is read at `pc`).

---
 rtl/pc_sequencer_if.sv | 36 +++
 rtl/pc_sequencer.sv | 90 +++++++++
 tb/tb_pc_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Bundles the run-control handshake, branch inputs, jump-table write port
// and the sequencer's registered outputs.
//
// Handshake: start is a one-cycle request pulse accepted in IDLE or DONE.
// run acknowledges it on the next cycle and stays high while instructions
// execute. done rises the cycle after a halt and holds until the next start.
// state is a debug view of the sequencer FSM (0=IDLE, 1=RUN, 2=DONE).
interface pc_sequencer_if #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 4,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              halt;
    logic              branch;
    logic              taken;
    logic [LUT_AW-1:0] lut_sel;
    logic              lut_we;
    logic [LUT_AW-1:0] lut_waddr;
    logic [PC_W-1:0]   lut_wdata;
    logic [PC_W-1:0]   pc;
    logic              run;
    logic              done;
    logic [CNT_W-1:0]  icount;
    logic [1:0]        state;

    modport master (
        output start, halt, branch, taken, lut_sel, lut_we, lut_waddr, lut_wdata,
        input  pc, run, done, icount, state
    );

    modport slave (
        input  start, halt, branch, taken, lut_sel, lut_we, lut_waddr, lut_wdata,
        output pc, run, done, icount, state
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and run control for the single-cycle core. Advances pc
// each cycle, redirects through a writable jump table on taken branches,
// and tracks start/halt with an instruction counter.
module pc_sequencer #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         reset,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LUT_N = 2 ** LUT_AW;

    state_t          state;
    logic [PC_W-1:0] lut [LUT_N];

    assign bus.state = state;

    // Jump table: cleared on reset; a write lands at the edge, so a branch in
    // the same cycle still sees the old entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LUT_N; i++) begin
                lut[i] <= '0;
            end
        end else if (bus.lut_we) begin
            lut[bus.lut_waddr] <= bus.lut_wdata;
        end
    end

    // Run-control FSM with registered pc, run, done and icount.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bus.pc     <= '0;
            bus.icount <= '0;
            bus.run    <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.pc <= '0;
                    if (bus.start) begin
                        state      <= RUN;
                        bus.icount <= '0;
                        bus.run    <= 1'b1;
                        bus.done   <= 1'b0;
                    end
                end
                RUN: begin
                    // Every RUN cycle executes one instruction, halt included.
                    if (bus.icount != {CNT_W{1'b1}}) begin
                        bus.icount <= bus.icount + CNT_W'(1);
                    end
                    if (bus.halt) begin
                        state    <= DONE;
                        bus.run  <= 1'b0;
                        bus.done <= 1'b1;
                    end else if (bus.branch && bus.taken) begin
                        bus.pc <= lut[bus.lut_sel];
                    end else begin
                        bus.pc <= bus.pc + PC_W'(1);
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state      <= RUN;
                        bus.pc     <= '0;
                        bus.icount <= '0;
                        bus.run    <= 1'b1;
                        bus.done   <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.pc   <= '0;
                    bus.run  <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: a driver applies one input vector per
// cycle and pushes the reference model's expected outputs; a monitor pops
// and compares after every rising edge.
module tb_pc_sequencer;
    localparam int PC_W   = 10;
    localparam int LUT_AW = 4;
    localparam int CNT_W  = 16;
    localparam int EXP_W  = PC_W + 2 + CNT_W;

    logic clk;
    logic reset;

    pc_sequencer_if #(.PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(CNT_W)) bus ();

    pc_sequencer #(.PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int vectors    = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 running, 2 finished
    int m_mode;
    int m_pc;
    int m_cnt;
    int m_lut [16];

    function automatic logic [EXP_W-1:0] model_out();
        logic [PC_W-1:0]  p;
        logic [CNT_W-1:0] c;
        p = PC_W'(m_pc);
        c = CNT_W'(m_cnt);
        return {p, (m_mode == 1), (m_mode == 2), c};
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic rst, input logic st, input logic hl,
                        input logic br, input logic tk, input int sel,
                        input logic we, input int wa, input int wd);
        int target;
        @(negedge clk);
        reset         = rst;
        bus.start     = st;
        bus.halt      = hl;
        bus.branch    = br;
        bus.taken     = tk;
        bus.lut_sel   = LUT_AW'(sel);
        bus.lut_we    = we;
        bus.lut_waddr = LUT_AW'(wa);
        bus.lut_wdata = PC_W'(wd);
        if (rst) begin
            m_mode = 0;
            m_pc   = 0;
            m_cnt  = 0;
            for (int i = 0; i < 16; i++) m_lut[i] = 0;
        end else begin
            target = m_lut[sel];
            if (m_mode == 0) begin
                if (st) begin
                    m_mode = 1; m_pc = 0; m_cnt = 0;
                end
            end else if (m_mode == 1) begin
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                if (hl) m_mode = 2;
                else if (br && tk) m_pc = target;
                else m_pc = (m_pc + 1) % 1024;
            end else begin
                if (st) begin
                    m_mode = 1; m_pc = 0; m_cnt = 0;
                end
            end
            if (we) m_lut[wa] = wd;
        end
        exp_q.push_back(model_out());
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jump(input int sel);
        step(0, 0, 0, 1, 1, sel, 0, 0, 0);
    endtask

    task automatic wr(input int wa, input int wd);
        step(0, 0, 0, 0, 0, 0, 1, wa, wd);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EXP_W-1:0] got;
        logic [EXP_W-1:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {bus.pc, bus.run, bus.done, bus.icount};
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL outputs vec %0d: got pc=%h run=%b done=%b icount=%0d, expected pc=%h run=%b done=%b icount=%0d",
                             vectors, got[EXP_W-1 -: PC_W], got[CNT_W+1], got[CNT_W],
                             got[CNT_W-1:0], exp[EXP_W-1 -: PC_W], exp[CNT_W+1],
                             exp[CNT_W], exp[CNT_W-1:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        bus.start = 0; bus.halt = 0; bus.branch = 0; bus.taken = 0;
        bus.lut_sel = '0; bus.lut_we = 0; bus.lut_waddr = '0; bus.lut_wdata = '0;

        // reset state and idle hold
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        nop();
        nop();

        // start, count 0..3, halt at 3
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        nop(); nop(); nop();
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        nop();

        // jump-table writes while finished, then taken / not-taken branches
        wr(5, 'h120);
        wr(1, 'h010);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        jump(1);
        jump(5);
        jump(1);
        step(0, 0, 0, 1, 0, 5, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);

        // branch + taken + halt together: halt wins
        wr(3, 'h040);
        jump(3);
        step(0, 0, 1, 1, 1, 5, 0, 0, 0);
        nop();

        // wrap from the top address
        step(0, 1, 0, 0, 0, 0, 1, 4, 'h3FF);
        jump(4);
        nop();
        nop();

        // same-cycle write and read of entry 2
        wr(2, 'h0AA);
        step(0, 0, 0, 1, 1, 2, 1, 2, 'h155);
        jump(2);

        // reset mid-run beats start and lut_we
        wr(6, 'h07B);
        jump(6);
        step(1, 1, 0, 0, 0, 0, 1, 7, 'h3AB);
        nop();
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        jump(5);
        jump(7);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        nop();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 1), $urandom_range(0, 15),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 15),
                 $urandom_range(0, 1023));
        end

        // long run to reach icount saturation
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 65545; n++) begin
            step(0, ($urandom_range(0, 7) == 0), 0, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 1) == 1), $urandom_range(0, 15),
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 15),
                 $urandom_range(0, 1023));
        end
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        nop();

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
